// File: rtl/uart_lb_pkg.sv
// Shared types and constants for the UART loopback controller.
package uart_lb_pkg;

    typedef enum logic [1:0] {
        ECHO  = 2'd0,
        LINE  = 2'd1,
        UPPER = 2'd2,
        DROP  = 2'd3
    } uart_mode_e;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } lb_state_e;

    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] LC_LO    = 8'h61;
    localparam logic [7:0] LC_HI    = 8'h7A;
    localparam logic [7:0] CASE_OFS = 8'h20;

    // Fold ASCII lower-case letters to upper case; other bytes pass through.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= LC_LO && b <= LC_HI) begin
            return b - CASE_OFS;
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_lb_fifo.sv
// Byte FIFO with registered head output, first-word fall-through after one cycle.
module uart_lb_fifo
    import uart_lb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_nxt;

    // The extra pointer MSB separates a full ring from an empty one.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level      = wr_ptr - rd_ptr;
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

    // Pointer update; only control state is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Head register: bypass the incoming byte when it becomes the new head.
    always_ff @(posedge clk) begin
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_ptr_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/uart_loopback_ctrl.sv
// UART loopback controller: transforms received bytes, buffers them and
// releases them to the transmitter, with a line-buffered release mode.
module uart_loopback_ctrl
    import uart_lb_pkg::*;
#(
    parameter int CLK_FREQ = 50,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16,
    parameter int NSTOP    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic                     clr_stat,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    output logic [15:0]              cfg_div,
    output logic                     cfg_txen,
    output logic                     cfg_rxen,
    output logic                     cfg_nstop,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int          AW       = $clog2(DEPTH);
    localparam longint      DIV_LL   = (longint'(CLK_FREQ) * 64'd1000000) / longint'(BAUD) - 1;
    localparam logic [15:0] DIV16    = 16'(DIV_LL);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    if (DIV_LL > 65535 || DIV_LL < 0) begin : g_bad_div
        $error("uart_loopback_ctrl: baud divisor out of 16-bit range");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_loopback_ctrl: DEPTH must be a power of two, at least 2");
    end

    assign cfg_div   = DIV16;
    assign cfg_txen  = 1'b1;
    assign cfg_rxen  = 1'b1;
    assign cfg_nstop = 1'(NSTOP);

    uart_mode_e  mode_e;
    lb_state_e   state;
    logic        push;
    logic        pop;
    logic        drop;
    logic        full;
    logic        empty;
    logic [7:0]  wr_byte;
    logic [AW:0] level_nxt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign mode_e    = uart_mode_e'(mode);
    assign wr_byte   = (mode_e == UPPER) ? to_upper(rx_data) : rx_data;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push      = rx_valid && (mode_e != DROP) && (!full || pop);
    assign drop      = rx_valid && (mode_e != DROP) && full && !pop;
    assign tx_valid  = !empty && ((mode_e != LINE) || (state == DRAIN));
    assign pop       = tx_valid && tx_ready;
    assign level_nxt = fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    uart_lb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_byte),
        .pop     (pop),
        .rd_data (tx_data),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    // Release FSM: hold bytes until a line end or a full buffer, then drain to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            case (state)
                FILL: begin
                    if ((push && wr_byte == LF) || level_nxt == FULL_LVL) state <= DRAIN;
                end
                DRAIN: begin
                    if (level_nxt == '0) state <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

    // Drop statistics; a drop in the clearing cycle counts as the first new drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= clr_stat ? 16'd1 : sat_inc(drop_cnt);
        end else if (clr_stat) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule
